// File: rtl/adder_pkg.sv
// Shared definitions for the adder datapath stages.
//   DEF_SWIDTH    : default width of the adder's signed sum samples.
//   out_state_e   : two-state output register FSM (EMPTY / FULL).
//   calc_cw()     : window counter width, max(1, clog2(len)).
//   sat_max/min() : most positive / most negative value of a w-bit signed
//                   number, returned as 64-bit signed so callers can
//                   size-cast to whatever width they compare at.
package adder_pkg;

  localparam int DEF_SWIDTH = 8;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  function automatic int calc_cw(input int len);
    return (len <= 2) ? 1 : $clog2(len);
  endfunction

  function automatic logic signed [63:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/adder_accum_if.sv
// Bus bundle between the signed adder (upstream), the window accumulator and
// the statistics logic (downstream).
//   clear                         : restart the window in progress.
//   in_valid/in_ready/in_data     : sample stream into the accumulator.
//   out_valid/out_ready/out_total,
//   out_zero/out_sat              : one result per completed window.
// Handshake: a transfer happens on a rising clk edge where valid && ready.
// The producer keeps valid and data stable until that edge; ready may depend
// combinationally on the other side's signals, valid never depends on ready.
// master = the environment around the accumulator, slave = the accumulator.
interface adder_accum_if #(
  parameter int SWIDTH = 8,
  parameter int AWIDTH = SWIDTH + 4
) ();

  logic                     clear;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [SWIDTH-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [AWIDTH-1:0] out_total;
  logic                     out_zero;
  logic                     out_sat;

  modport master (
    output clear, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_total, out_zero, out_sat
  );

  modport slave (
    input  clear, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_total, out_zero, out_sat
  );

endinterface

// File: rtl/sat_add.sv
// Combinational signed add with clamping to an OW-bit signed result.
//   a_i   : AW-bit signed operand.
//   b_i   : BW-bit signed operand.
//   sum_o : OW-bit signed result, clamped to [-2^(OW-1), 2^(OW-1)-1].
//   ovf_o : high when the clamp was applied.
module sat_add
  import adder_pkg::*;
#(
  parameter int AW = 12,
  parameter int BW = 8,
  parameter int OW = 12
) (
  input  logic signed [AW-1:0] a_i,
  input  logic signed [BW-1:0] b_i,
  output logic signed [OW-1:0] sum_o,
  output logic                 ovf_o
);

  // One bit wider than the widest of the three widths, so the raw sum never
  // wraps and both clamp bounds are representable.
  localparam int MW = (AW > BW) ? AW : BW;
  localparam int IW = ((MW > OW) ? MW : OW) + 1;

  localparam logic signed [IW-1:0] MAXV = IW'(sat_max(OW));
  localparam logic signed [IW-1:0] MINV = IW'(sat_min(OW));

  logic signed [IW-1:0] a_ext;
  logic signed [IW-1:0] b_ext;
  logic signed [IW-1:0] raw;

  assign a_ext = {{(IW - AW){a_i[AW-1]}}, a_i};
  assign b_ext = {{(IW - BW){b_i[BW-1]}}, b_i};
  assign raw   = a_ext + b_ext;

  always_comb begin
    sum_o = raw[OW-1:0];
    ovf_o = 1'b0;
    if (raw > MAXV) begin
      sum_o = MAXV[OW-1:0];
      ovf_o = 1'b1;
    end else if (raw < MINV) begin
      sum_o = MINV[OW-1:0];
      ovf_o = 1'b1;
    end
  end

endmodule

// File: rtl/adder_accum.sv
// Windowed saturating accumulator behind the signed adder.
// Sums LEN consecutive accepted samples, clamping at every step, and emits
// one total per window together with a zero flag and a sticky saturation
// flag. The output is a registered slot; while it is held unaccepted the
// input stalls.
//   clk, rst  : clock and synchronous active-high reset.
//   bus       : adder_accum_if slave (clear, input stream, output result).
//   state_o   : output FSM state (ST_FULL exactly when out_valid is high).
module adder_accum
  import adder_pkg::*;
#(
  parameter int SWIDTH = DEF_SWIDTH,
  parameter int LEN    = 4,
  parameter int AWIDTH = SWIDTH + 4
) (
  input  logic        clk,
  input  logic        rst,
  adder_accum_if.slave bus,
  output out_state_e  state_o
);

  localparam int            CW   = calc_cw(LEN);
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  logic signed [AWIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     sacc_q, sacc_d;
  out_state_e               state_q, state_d;
  logic signed [AWIDTH-1:0] total_q, total_d;
  logic                     zero_q, zero_d;
  logic                     osat_q, osat_d;

  logic signed [AWIDTH-1:0] sat_sum;
  logic                     clamp;
  logic                     in_ready;
  logic                     in_fire;
  logic                     out_fire;
  logic                     final_acc;

  // The slot is free when empty, or when it is being drained this cycle.
  assign in_ready  = (state_q == ST_EMPTY) || bus.out_ready;
  assign in_fire   = bus.in_valid && in_ready;
  assign out_fire  = (state_q == ST_FULL) && bus.out_ready;
  // clear wins over a simultaneous accept, so that sample never closes a window.
  assign final_acc = !bus.clear && in_fire && (cnt_q == LAST);

  sat_add #(
    .AW(AWIDTH),
    .BW(SWIDTH),
    .OW(AWIDTH)
  ) u_sat_add (
    .a_i  (acc_q),
    .b_i  (bus.in_data),
    .sum_o(sat_sum),
    .ovf_o(clamp)
  );

  // Window datapath: accumulator, counter, sticky flag and result register.
  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sacc_d  = sacc_q;
    total_d = total_q;
    zero_d  = zero_q;
    osat_d  = osat_q;
    if (bus.clear) begin
      acc_d  = '0;
      cnt_d  = '0;
      sacc_d = 1'b0;
    end else if (in_fire) begin
      if (cnt_q == LAST) begin
        total_d = sat_sum;
        zero_d  = (sat_sum == '0);
        osat_d  = sacc_q | clamp;
        acc_d   = '0;
        cnt_d   = '0;
        sacc_d  = 1'b0;
      end else begin
        acc_d  = sat_sum;
        cnt_d  = cnt_q + 1'b1;
        sacc_d = sacc_q | clamp;
      end
    end
  end

  // Output slot FSM. A final accept while FULL implies out_fire (in_ready
  // needs out_ready), so the new result simply replaces the drained one.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (final_acc) state_d = ST_FULL;
      ST_FULL:  if (out_fire && !final_acc) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      sacc_q  <= 1'b0;
      state_q <= ST_EMPTY;
      total_q <= '0;
      zero_q  <= 1'b0;
      osat_q  <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sacc_q  <= sacc_d;
      state_q <= state_d;
      total_q <= total_d;
      zero_q  <= zero_d;
      osat_q  <= osat_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == ST_FULL);
  assign bus.out_total = total_q;
  assign bus.out_zero  = zero_q;
  assign bus.out_sat   = osat_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_adder_accum.sv
module tb_adder_accum;
  import adder_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus, fanned out to three configurations:
  //   k=0 : LEN=4, AWIDTH=12   k=1 : LEN=4, AWIDTH=9   k=2 : LEN=1, AWIDTH=12
  logic              clear;
  logic              in_valid;
  logic signed [7:0] in_data;
  logic              out_ready;

  adder_accum_if #(.SWIDTH(8), .AWIDTH(12)) b0 ();
  adder_accum_if #(.SWIDTH(8), .AWIDTH(9))  b1 ();
  adder_accum_if #(.SWIDTH(8), .AWIDTH(12)) b2 ();

  assign b0.clear = clear;  assign b0.in_valid = in_valid;
  assign b0.in_data = in_data;  assign b0.out_ready = out_ready;
  assign b1.clear = clear;  assign b1.in_valid = in_valid;
  assign b1.in_data = in_data;  assign b1.out_ready = out_ready;
  assign b2.clear = clear;  assign b2.in_valid = in_valid;
  assign b2.in_data = in_data;  assign b2.out_ready = out_ready;

  out_state_e st0, st1, st2;

  adder_accum #(.SWIDTH(8), .LEN(4), .AWIDTH(12)) u0 (
    .clk(clk), .rst(rst), .bus(b0), .state_o(st0));
  adder_accum #(.SWIDTH(8), .LEN(4), .AWIDTH(9)) u1 (
    .clk(clk), .rst(rst), .bus(b1), .state_o(st1));
  adder_accum #(.SWIDTH(8), .LEN(1), .AWIDTH(12)) u2 (
    .clk(clk), .rst(rst), .bus(b2), .state_o(st2));

  // Observed outputs gathered into arrays indexed by configuration.
  longint tot[3];
  logic   rdy[3], vld[3], zro[3], sat[3], stf[3];
  always_comb begin
    rdy[0] = b0.in_ready;  vld[0] = b0.out_valid;  zro[0] = b0.out_zero;
    sat[0] = b0.out_sat;   tot[0] = longint'(b0.out_total);  stf[0] = (st0 == ST_FULL);
    rdy[1] = b1.in_ready;  vld[1] = b1.out_valid;  zro[1] = b1.out_zero;
    sat[1] = b1.out_sat;   tot[1] = longint'(b1.out_total);  stf[1] = (st1 == ST_FULL);
    rdy[2] = b2.in_ready;  vld[2] = b2.out_valid;  zro[2] = b2.out_zero;
    sat[2] = b2.out_sat;   tot[2] = longint'(b2.out_total);  stf[2] = (st2 == ST_FULL);
  end

  // ---------------- reference model ----------------
  // Per configuration: list of samples accepted in the open window and the
  // result currently offered on the output slot.
  int     len_k[3] = '{4, 4, 1};
  int     aw_k[3]  = '{12, 9, 12};
  longint win[3][256];
  int     wn[3];
  bit     m_vld[3];
  longint m_tot[3];
  bit     m_zro[3];
  bit     m_sat[3];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Window total: running sum of the window's samples, pinned to the
  // AWIDTH signed range after every addition.
  task automatic fold(input int k, output longint t, output bit s);
    longint mx;
    longint mn;
    mx = (longint'(1) <<< (aw_k[k] - 1)) - 1;
    mn = -(mx + 1);
    t = 0;
    s = 1'b0;
    for (int i = 0; i < wn[k]; i++) begin
      t = t + win[k][i];
      if (t > mx) begin t = mx; s = 1'b1; end
      if (t < mn) begin t = mn; s = 1'b1; end
    end
  endtask

  // Predict the state after the coming rising edge from the current inputs.
  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      bit     rdy_e;
      bit     ofire;
      bit     fin;
      longint t;
      bit     s;
      rdy_e = !m_vld[k] || out_ready;
      if (rst) begin
        m_vld[k] = 0; m_tot[k] = 0; m_zro[k] = 0; m_sat[k] = 0; wn[k] = 0;
      end else begin
        ofire = m_vld[k] && out_ready;
        fin   = 0;
        if (clear) begin
          wn[k] = 0;
        end else if (in_valid && rdy_e) begin
          win[k][wn[k]] = longint'(in_data);
          wn[k]++;
          if (wn[k] == len_k[k]) begin
            fold(k, t, s);
            m_vld[k] = 1; m_tot[k] = t; m_zro[k] = (t == 0); m_sat[k] = s;
            wn[k] = 0;
            fin = 1;
          end
        end
        if (ofire && !fin) m_vld[k] = 0;
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("in_ready[%0d]", k), longint'(rdy[k]), longint'(!m_vld[k] || out_ready));
      chk($sformatf("out_valid[%0d]", k), longint'(vld[k]), longint'(m_vld[k]));
      chk($sformatf("state_full[%0d]", k), longint'(stf[k]), longint'(m_vld[k]));
      chk($sformatf("out_total[%0d]", k), tot[k], m_tot[k]);
      chk($sformatf("out_zero[%0d]", k), longint'(zro[k]), longint'(m_zro[k]));
      chk($sformatf("out_sat[%0d]", k), longint'(sat[k]), longint'(m_sat[k]));
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after the rising edge; outputs are compared
  // at the falling edge, then the model advances over the next rising edge.
  task automatic cycle();
    @(negedge clk);
    check_all();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int v);
    in_valid = 1'b1;
    in_data  = 8'(v);
    cycle();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    cycle();
  endtask

  task automatic chk_out(input string tag, input int k, input longint v,
                         input longint t, input longint z, input longint s);
    chk({tag, "_valid"}, longint'(vld[k]), v);
    chk({tag, "_total"}, tot[k], t);
    chk({tag, "_zero"},  longint'(zro[k]), z);
    chk({tag, "_sat"},   longint'(sat[k]), s);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wn[k] = 0; m_vld[k] = 0; m_tot[k] = 0; m_zro[k] = 0; m_sat[k] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk_out($sformatf("reset%0d", k), k, 0, 0, 0, 0);
      chk($sformatf("reset_ready%0d", k), longint'(rdy[k]), 1);
    end

    // Basic window 1,2,3,4.
    feed(1); feed(2); feed(3);
    chk("basic_early_valid", longint'(vld[0]), 0);
    feed(4);
    chk_out("basic", 0, 1, 10, 0, 0);
    idle();
    chk("basic_drop_valid", longint'(vld[0]), 0);

    // Saturation on the 9-bit accumulator.
    repeat (4) feed(127);
    chk_out("sat_pos", 1, 1, 255, 0, 1);
    chk_out("nosat_pos", 0, 1, 508, 0, 0);
    repeat (4) feed(-128);
    chk_out("sat_neg", 1, 1, -256, 0, 1);
    feed(5); feed(-5); feed(0); feed(0);
    chk_out("zero_win", 1, 1, 0, 1, 0);
    idle();

    // Backpressure: result held, nothing consumed while stalled.
    out_ready = 1'b0;
    feed(10); feed(20); feed(30); feed(40);
    chk_out("bp_load", 0, 1, 100, 0, 0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_ready", longint'(rdy[0]), 0);
      feed(99);
      chk("bp_hold_total", tot[0], 100);
      chk("bp_hold_valid", longint'(vld[0]), 1);
    end
    out_ready = 1'b1;
    in_data   = 8'(2);
    #1;
    chk("bp_resume_ready", longint'(rdy[0]), 1);
    repeat (4) feed(2);
    chk_out("bp_next", 0, 1, 8, 0, 0);
    idle();

    // Clear mid-window drops the partial sum and the concurrent sample.
    feed(7); feed(7);
    clear = 1'b1;
    feed(9);
    clear = 1'b0;
    chk("clear_no_out", longint'(vld[0]), 0);
    repeat (4) feed(1);
    chk_out("after_clear", 0, 1, 4, 0, 0);
    idle();

    // Reset mid-window.
    feed(3); feed(3);
    in_valid = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) chk_out($sformatf("mid_rst%0d", k), k, 0, 0, 0, 0);
    feed(1); feed(2); feed(3); feed(4);
    chk_out("after_rst", 0, 1, 10, 0, 0);
    idle();

    // LEN=1 streaming.
    feed(-3);
    chk_out("len1_a", 2, 1, -3, 0, 0);
    feed(0);
    chk_out("len1_b", 2, 1, 0, 1, 0);
    feed(50);
    chk_out("len1_c", 2, 1, 50, 0, 0);
    idle();
    chk("len1_drop", longint'(vld[2]), 0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 4) != 0);
      clear     = ($urandom_range(0, 24) == 0);
      rst       = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 3) == 0)
        in_data = ($urandom_range(0, 1) == 0) ? 8'sd127 : -8'sd128;
      else
        in_data = 8'($urandom_range(0, 255));
      cycle();
    end
    rst = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cycle();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_accum.md
Name: adder_accum

Overview:
- Downstream stage of the signed adder. Consumes the adder's registered sum stream (SWIDTH signed) through a valid/ready handshake.
- Accumulates LEN consecutive accepted sums with saturating arithmetic. Emits one windowed total per LEN inputs on a registered valid/ready output.
- Also reports a zero flag and a sticky per-window saturation flag. Feeds the statistics/threshold logic that follows the adder path.

Parameters:
- SWIDTH, 8, signed width of incoming sum samples.
- LEN, 4, samples per window; legal range 1..256.
- AWIDTH, SWIDTH+4, signed width of the accumulator and the output total; must be >= SWIDTH.

Ports:
- clk  input  1  single clock; all logic on its rising edge.
- rst  input  1  synchronous reset, active-high.
- clear  input  1  synchronous restart of the window in progress.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept in_data this cycle.
- in_data  input  SWIDTH  signed sum sample.
- out_valid  output  1  out_total, out_zero and out_sat are valid.
- out_ready  input  1  consumer accepts the output this cycle.
- out_total  output  AWIDTH  signed saturated window total.
- out_zero  output  1  out_total == 0.
- out_sat  output  1  saturation occurred at least once in this window.

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-high (rst), sampled on the clk rising edge.
- Reset: acc=0, cnt=0, sat_acc=0, out_valid=0, out_total=0, out_zero=0, out_sat=0. Reset mid-window discards the partial window and any pending output.
- in_fire = in_valid && in_ready. out_fire = out_valid && out_ready.
- in_ready = !out_valid || out_ready. This is combinational; it gives full throughput when the consumer is ready and stalls only while an output is held.
- Saturating add: sum = sext(acc) + sext(in_data), computed at AWIDTH+1 bits.
  - Clamp to [-2^(AWIDTH-1), 2^(AWIDTH-1)-1].
  - Set the per-window sat flag if a clamp occurred.
  - The accumulator holds the clamped value, so saturation persists until the window closes.
- Non-final accept (in_fire, cnt < LEN-1): acc <= sat_sum, cnt <= cnt+1, sat_acc <= sat_acc | clamp.
- Final accept (in_fire, cnt == LEN-1):
  - out_total <= sat_sum, out_sat <= sat_acc | clamp, out_zero <= (sat_sum == 0), out_valid <= 1.
  - acc <= 0, cnt <= 0, sat_acc <= 0.
- Latency: outputs are valid in the cycle after the final accept.
- Output hold: while out_valid && !out_ready, out_total, out_zero and out_sat stay stable and in_ready = 0.
- out_fire without a new final accept: out_valid <= 0. out_fire with a new final accept in the same cycle: out_valid stays 1 and the new result loads (back-to-back; only possible when LEN == 1).
- LEN == 1: every accepted sample produces an output; cnt is constant 0.
- clear (when not in rst): acc <= 0, cnt <= 0, sat_acc <= 0. It does not affect a pending output (out_valid, out_total, out_zero, out_sat). If clear and in_fire occur in the same cycle, clear wins and the sample is dropped; in_ready is not affected by clear.
- Priority: rst > clear > in_fire.
- Counter width: CW = max(1, clog2(LEN)).
- State: a two-state output FSM encoded by out_valid.
  - EMPTY -> FULL on final accept.
  - FULL -> EMPTY on out_fire without a final accept.
  - FULL -> FULL on out_fire with a final accept.

Decomposition:
- Shared package adder_pkg:
  - sat_max(w) and sat_min(w) constant functions.
  - Default SWIDTH (8).
  - CW computation function.
- Sub-module sat_add (parameters AW, BW, OW): combinational signed add with clamp and an overflow flag. Reused by later saturating stages.
- The accumulator, counter and output register stay in adder_accum.

Test Plan:
- All tests use SWIDTH=8 unless stated.
- Basic window (LEN=4, AWIDTH=12): inputs 1,2,3,4 with out_ready=1 -> out_total=10, out_zero=0, out_sat=0, out_valid exactly one cycle after the 4th accept, then 0.
- Saturation (LEN=4, AWIDTH=9): four inputs of 127 -> out_total=255, out_sat=1. Next window of -128 x4 -> out_total=-256, out_sat=1. Next window 5,-5,0,0 -> out_total=0, out_zero=1, out_sat=0.
- Backpressure (LEN=4): complete a window with out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, out_total stable, no samples consumed. Raise out_ready -> accept resumes the same cycle, and the next window sum is correct.
- Clear and reset mid-window: feed 7,7 then clear with in_valid=1 and in_data=9 -> 9 dropped, next 1,1,1,1 gives out_total=4. Feed 3,3 then rst=1 for one cycle -> all outputs 0, and the next window is computed from fresh.
- LEN=1 streaming: inputs -3,0,50 continuously with out_ready=1 -> out_total -3,0,50 on consecutive cycles, out_zero=1 only for the second, out_valid held high throughout.
